// File: rtl/sbox_x26_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the x26 S-box
// BRAM column sequencer.
package sbox_x26_pkg;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned COL_W  = 4 * DATA_W;
  localparam int unsigned SEL_W  = ADDR_W - DATA_W;

  localparam int unsigned LANE0 = 0;
  localparam int unsigned LANE1 = 1;
  localparam int unsigned LANE2 = 2;
  localparam int unsigned LANE3 = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE0 = 2'd1,
    ISSUE1 = 2'd2
  } state_t;

  // Table address for one byte lane of a column: {region select, byte}.
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [SEL_W-1:0] sel,
                                                input logic [COL_W-1:0] col,
                                                input int unsigned      lane);
    return {sel, col[lane*DATA_W +: DATA_W]};
  endfunction

endpackage

// File: rtl/sbox_x26_bram_seq_if.sv
// Column stream and BRAM read-port bundle between the sequencer and its
// upstream producer, downstream consumer and the dual-port table BRAM.
interface sbox_x26_bram_seq_if;
  import sbox_x26_pkg::*;

  // Handshake: a column transfers on every rising edge where in_valid and
  // in_ready are both high; while in_valid is high and in_ready low the
  // producer holds in_col/in_sel stable. out_valid is a one-cycle pulse with
  // no ready: the consumer must take out_col in that cycle.
  logic              in_valid;
  logic              in_ready;
  logic [COL_W-1:0]  in_col;
  logic [SEL_W-1:0]  in_sel;

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addra;
  logic [ADDR_W-1:0] bram_addrb;
  logic [DATA_W-1:0] bram_doa;
  logic [DATA_W-1:0] bram_dob;

  logic              out_valid;
  logic [COL_W-1:0]  out_col;

  modport master (
    output in_valid, in_col, in_sel, bram_doa, bram_dob,
    input  in_ready, bram_en, bram_addra, bram_addrb, out_valid, out_col
  );

  modport slave (
    input  in_valid, in_col, in_sel, bram_doa, bram_dob,
    output in_ready, bram_en, bram_addra, bram_addrb, out_valid, out_col
  );

endinterface

// File: rtl/sbox_x26_vld_pipe.sv
// DEPTH-deep delay line for the {vld, half} read tag, aligning each issued
// address pair with the BRAM data it produces.
module sbox_x26_vld_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_half,
  output logic out_vld,
  output logic out_half
);

  logic vld_sr  [DEPTH];
  logic half_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_sr[i]  <= 1'b0;
        half_sr[i] <= 1'b0;
      end
    end else begin
      vld_sr[0]  <= in_vld;
      half_sr[0] <= in_half;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        half_sr[i] <= half_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[DEPTH-1];
  assign out_half = half_sr[DEPTH-1];

endmodule

// File: rtl/sbox_x26_bram_seq.sv
// Column sequencer: splits a 32-bit masked column into two byte-pair reads of
// the dual-port S-box BRAM and reassembles the looked-up bytes into a column.
module sbox_x26_bram_seq
  import sbox_x26_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sbox_x26_bram_seq_if.slave  bus,
  output state_t              dbg_state
);

  state_t             state;
  logic [COL_W-1:0]   col_q;
  logic [SEL_W-1:0]   sel_q;
  logic [ADDR_W-1:0]  addra_q;
  logic [ADDR_W-1:0]  addrb_q;
  logic               iss_vld;
  logic               iss_half;
  logic               tag_vld;
  logic               tag_half;
  logic [DATA_W-1:0]  byte0_q;
  logic [DATA_W-1:0]  byte1_q;
  logic               out_valid_q;
  logic [COL_W-1:0]   out_col_q;
  logic               accept;

  // ISSUE1 can take the next column so back-to-back columns run at 1 per 2 cycles.
  assign bus.in_ready = !rst && (state == IDLE || state == ISSUE1);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.bram_en  = !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col_q    <= '0;
      sel_q    <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      iss_vld  <= 1'b0;
      iss_half <= 1'b0;
    end else begin
      iss_vld  <= 1'b0;
      iss_half <= 1'b0;
      if (accept) begin
        col_q <= bus.in_col;
        sel_q <= bus.in_sel;
      end
      case (state)
        IDLE: begin
          if (accept) state <= ISSUE0;
        end
        ISSUE0: begin
          addra_q  <= mk_addr(sel_q, col_q, LANE0);
          addrb_q  <= mk_addr(sel_q, col_q, LANE1);
          iss_vld  <= 1'b1;
          iss_half <= 1'b0;
          state    <= ISSUE1;
        end
        ISSUE1: begin
          // col_q/sel_q still hold the current column here; a new accept
          // only overwrites them at this same edge.
          addra_q  <= mk_addr(sel_q, col_q, LANE2);
          addrb_q  <= mk_addr(sel_q, col_q, LANE3);
          iss_vld  <= 1'b1;
          iss_half <= 1'b1;
          state    <= accept ? ISSUE0 : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bram_addra = addra_q;
  assign bus.bram_addrb = addrb_q;
  assign dbg_state      = state;

  // The tag enters alongside the registered address, so after RD_LAT stages
  // it lines up with the BRAM output register.
  sbox_x26_vld_pipe #(
    .DEPTH (RD_LAT)
  ) u_vld_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (iss_vld),
    .in_half  (iss_half),
    .out_vld  (tag_vld),
    .out_half (tag_half)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      byte0_q     <= '0;
      byte1_q     <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (tag_vld && !tag_half) begin
        byte0_q <= bus.bram_doa;
        byte1_q <= bus.bram_dob;
      end
      if (tag_vld && tag_half) begin
        out_col_q   <= {bus.bram_dob, bus.bram_doa, byte1_q, byte0_q};
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;

endmodule
